// File: rtl/register_file_32x_pkg.sv
// Shared constants and helpers for the 32-entry register file.
package register_file_32x_pkg;

  localparam int ADDR_W = 5;
  localparam int REG_COUNT = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  // True when a read address collides with an active, non-discarded write
  function automatic logic byp_hit(input logic we, input logic rst,
                                   input logic [ADDR_W-1:0] sw,
                                   input logic [ADDR_W-1:0] sa);
    return we && !rst && (sw != ZERO_REG) && (sa == sw);
  endfunction

endpackage

// File: rtl/register_file_32x_mux.sv
// 32:1 N-bit read-select multiplexer.
module mux32_nbit
  import register_file_32x_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [REG_COUNT-1:0][N-1:0] d,
  input  logic [ADDR_W-1:0]           sel,
  output logic [N-1:0]                y
);

  // Plain indexed select; every address is a valid input
  always_comb begin
    y = d[sel];
  end

endmodule

// File: rtl/register_file_32x_reg.sv
// Single N-bit storage register with synchronous clear and load enable.
module register_nbit #(
  parameter int N = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q
);

  // Clear wins over load so a write in the reset cycle is discarded
  always_ff @(posedge clock) begin
    if (reset)     Q <= '0;
    else if (load) Q <= D;
  end

endmodule

// File: rtl/register_file_32x.sv
// 32-entry N-bit register file: two combinational read ports, one
// synchronous write port, entry 31 hard-wired to zero.
module register_file_32x
  import register_file_32x_pkg::*;
#(
  parameter int N      = 64,
  parameter int BYPASS = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N-1:0]      W,
  input  logic [ADDR_W-1:0] SW,
  input  logic              WE,
  input  logic [ADDR_W-1:0] SA,
  input  logic [ADDR_W-1:0] SB,
  output logic [N-1:0]      A,
  output logic [N-1:0]      B
);

  logic [REG_COUNT-2:0]          load;
  logic [REG_COUNT-1:0][N-1:0]   q_all;
  logic [N-1:0]                  mux_a;
  logic [N-1:0]                  mux_b;

  // One-hot write decode; address 31 has no load line so it drops out
  always_comb begin
    load = '0;
    for (int i = 0; i < REG_COUNT - 1; i++) begin
      load[i] = WE && (SW == ADDR_W'(i));
    end
  end

  for (genvar i = 0; i < REG_COUNT - 1; i++) begin : g_reg
    register_nbit #(.N(N)) u_reg (
      .clock (clock),
      .reset (reset),
      .load  (load[i]),
      .D     (W),
      .Q     (q_all[i])
    );
  end

  assign q_all[REG_COUNT-1] = '0;

  mux32_nbit #(.N(N)) u_mux_a (
    .d   (q_all),
    .sel (SA),
    .y   (mux_a)
  );

  mux32_nbit #(.N(N)) u_mux_b (
    .d   (q_all),
    .sel (SB),
    .y   (mux_b)
  );

  if (BYPASS != 0) begin : g_byp
    // Forward write data to a colliding read so it sees the new value early
    always_comb begin
      A = byp_hit(WE, reset, SW, SA) ? W : mux_a;
      B = byp_hit(WE, reset, SW, SB) ? W : mux_b;
    end
  end else begin : g_nobyp
    // Reads always reflect the stored state
    always_comb begin
      A = mux_a;
      B = mux_b;
    end
  end

endmodule

// File: tb/tb_register_file_32x.sv
// Scoreboard bench for register_file_32x, checking BYPASS=0 and BYPASS=1
// instances side by side on identical stimulus.
module tb_register_file_32x;

  localparam logic [63:0] K5 = 64'h0123_4567_89AB_CDEF;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] W;
  logic [4:0]  SW;
  logic        WE;
  logic [4:0]  SA;
  logic [4:0]  SB;
  logic [63:0] a0, b0, a1, b1;

  always #5 clock = ~clock;

  register_file_32x #(.N(64), .BYPASS(0)) u_dut0 (
    .clock (clock), .reset (reset), .W (W), .SW (SW), .WE (WE),
    .SA (SA), .SB (SB), .A (a0), .B (b0)
  );

  register_file_32x #(.N(64), .BYPASS(1)) u_dut1 (
    .clock (clock), .reset (reset), .W (W), .SW (SW), .WE (WE),
    .SA (SA), .SB (SB), .A (a1), .B (b1)
  );

  typedef struct {
    logic [63:0] a0, b0, a1, b1;
    int          tag;
  } exp_t;

  exp_t        expq[$];
  logic        chk_vld = 1'b0;
  int          pass_cnt = 0;
  int          tot_cnt = 0;
  int          step_no = 0;
  logic [63:0] mem [32];

  task automatic cmp(input string nm, input int tag,
                     input logic [63:0] got, input logic [63:0] want);
    tot_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL step%0d %s got %h want %h", tag, nm, got, want);
  endtask

  // Monitor: the bench raises chk_vld for every cycle it wants observed
  always @(negedge clock) begin
    if (chk_vld) begin
      if (expq.size() == 0) begin
        tot_cnt++;
        $display("FAIL scoreboard_underflow got 0 entries want 1");
      end else begin
        exp_t e;
        e = expq.pop_front();
        cmp("A_byp0", e.tag, a0, e.a0);
        cmp("B_byp0", e.tag, b0, e.b0);
        cmp("A_byp1", e.tag, a1, e.a1);
        cmp("B_byp1", e.tag, b1, e.b1);
      end
    end
  end

  // Drive one cycle of inputs; the write model tracks committed state only
  task automatic drive(input logic rst, input logic we, input logic [4:0] sw,
                       input logic [63:0] w, input logic [4:0] sa,
                       input logic [4:0] sb, input logic chk,
                       input logic [63:0] ea0, input logic [63:0] eb0,
                       input logic [63:0] ea1, input logic [63:0] eb1);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst; WE = we; SW = sw; W = w; SA = sa; SB = sb;
    step_no++;
    if (chk) begin
      e.a0 = ea0; e.b0 = eb0; e.a1 = ea1; e.b1 = eb1; e.tag = step_no;
      expq.push_back(e);
    end
    chk_vld = chk;
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
    end else if (we && sw != 5'd31) begin
      mem[sw] = w;
    end
  endtask

  function automatic logic [63:0] rd(input logic [4:0] ad);
    return (ad == 5'd31) ? 64'd0 : mem[ad];
  endfunction

  // Read every address on A (ascending) and B (descending), no write active
  task automatic sweep();
    for (int a = 0; a < 32; a++) begin
      logic [4:0] sa, sb;
      sa = 5'(a);
      sb = 5'(31 - a);
      drive(0, 0, 5'd0, 64'd0, sa, sb, 1, rd(sa), rd(sb), rd(sa), rd(sb));
    end
  endtask

  initial begin
    reset = 1'b1; WE = 1'b0; SW = '0; W = '0; SA = '0; SB = '0;
    for (int i = 0; i < 32; i++) mem[i] = 'x;

    drive(1, 0, 5'd0, 64'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    sweep();

    // R5 write: reads elsewhere unaffected during the write cycle
    drive(0, 1, 5'd5, K5, 5'd0, 5'd1, 1, 0, 0, 0, 0);
    drive(0, 0, 5'd0, 64'd0, 5'd5, 5'd5, 1, K5, K5, K5, K5);
    sweep();

    // Writes to the zero register vanish, with and without bypass
    drive(0, 1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd5, 1, 0, K5, 0, K5);
    drive(0, 0, 5'd0, 64'd0, 5'd31, 5'd31, 1, 0, 0, 0, 0);
    sweep();

    // Write enable gating, then the committed write with bypass collision
    drive(0, 0, 5'd7, 64'h55, 5'd7, 5'd5, 1, 0, K5, 0, K5);
    drive(0, 0, 5'd0, 64'd0, 5'd7, 5'd7, 1, 0, 0, 0, 0);
    drive(0, 1, 5'd7, 64'h55, 5'd7, 5'd5, 1, 0, K5, 64'h55, K5);
    drive(0, 0, 5'd0, 64'd0, 5'd7, 5'd7, 1, 64'h55, 64'h55, 64'h55, 64'h55);

    // Same-cycle overwrite: old value without bypass, new value with it
    drive(0, 1, 5'd3, 64'h10, 5'd0, 5'd0, 1, 0, 0, 0, 0);
    drive(0, 1, 5'd3, 64'h20, 5'd3, 5'd3, 1, 64'h10, 64'h10, 64'h20, 64'h20);
    drive(0, 0, 5'd0, 64'd0, 5'd3, 5'd7, 1, 64'h20, 64'h55, 64'h20, 64'h55);

    // Reset beats a simultaneous write and suppresses bypass
    drive(0, 1, 5'd9, 64'hAA, 5'd5, 5'd3, 1, K5, 64'h20, K5, 64'h20);
    drive(1, 1, 5'd9, 64'hBB, 5'd9, 5'd5, 1, 64'hAA, K5, 64'hAA, K5);
    drive(0, 0, 5'd0, 64'd0, 5'd9, 5'd5, 1, 0, 0, 0, 0);
    drive(0, 1, 5'd9, 64'hBB, 5'd9, 5'd9, 1, 0, 0, 64'hBB, 64'hBB);
    drive(0, 0, 5'd0, 64'd0, 5'd9, 5'd3, 1, 64'hBB, 0, 64'hBB, 0);
    sweep();

    @(posedge clock);
    #1;
    chk_vld = 1'b0;
    WE = 1'b0;
    repeat (2) @(posedge clock);
    tot_cnt++;
    if (expq.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain got %0d entries want 0", expq.size());

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/register_file_32x.md
Name: register_file_32x

Overview:
- 32-entry, N-bit register file with two combinational read ports and one synchronous write port.
- Sits directly upstream of the 32:1 N-bit read-select muxes and the ALU operand path. It supplies the 32 stored words to those muxes, and the datapath writeback drives its write port.
- Register 31 is the zero register: it always reads 0 and ignores writes.

Parameters:
- N, 64, data width of each register and of all data ports
- BYPASS, 0, 1 = a read of the address being written this cycle returns write data; 0 = it returns the stored value

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all registers on the rising edge of clock
- W  input  N  write data
- SW  input  5  write address
- WE  input  1  write enable
- SA  input  5  read address, port A
- SB  input  5  read address, port B
- A  output  N  read data, port A
- B  output  N  read data, port B

Behaviour:
- Storage: R[0..30], N bits each. R[31] does not exist as state and is constant 0.
- Reset:
  - If reset=1 at a rising edge, R[0..30] become 0.
  - After that edge, A=B=0 for every address.
  - Reset has priority over a simultaneous write, so the write is dropped.
  - Reset asserted in the middle of a write sequence discards the write at that edge only.
  - Earlier completed writes are also cleared.
- Write:
  - At a rising edge with reset=0, WE=1 and SW!=31, R[SW] <= W.
  - WE=0 leaves all registers unchanged.
  - SW=31 is silently dropped, with no side effect on any register.
- Read:
  - A = (SA==31) ? 0 : R[SA], purely combinational from the current state.
  - B = (SB==31) ? 0 : R[SB], purely combinational from the current state.
  - A written value is visible on A/B from the cycle after the write edge (0-cycle read latency, 1-cycle write-to-read latency).
- Same-cycle read of the address being written (WE=1, SA==SW or SB==SW, SW!=31, reset=0):
  - BYPASS=0: the read port shows the old value.
  - BYPASS=1: the read port shows W combinationally.
  - The bypass is never applied when SW=31 or reset=1.
- Both read ports may address the same register in the same cycle. Each returns the identical value.
- All address values 0..31 are legal. There are no X outputs after the first reset.
- Before the first reset, register contents are undefined. The bench must apply reset first.

Decomposition:
- Shared package:
  - ZERO_REG = 5'd31
  - REG_COUNT = 32
  - ADDR_W = 5
- Sub-module register_nbit (parameter N):
  - Ports: clock, reset, load, D, Q.
  - Synchronous active-high clear; load-enable capture.
  - Instantiated 31 times.
- Write decode: a 5-to-32 one-hot decoder gated by WE, generating load[0..30]. It is inline logic.
- Read side: two instances of the team's existing 32:1 N-bit mux. Input 31 is tied to 0, inputs 0..30 are driven from the register Q outputs.

Test Plan:
- Reset, then sweep SA and SB from 0 to 31 -> A=B=0 at every address.
- Write R[5]=64'h0123_4567_89AB_CDEF with WE=1, SW=5, then read with SA=5, SB=5 the next cycle -> A=B=64'h0123_4567_89AB_CDEF. Other registers remain 0.
- Write SW=31 with W=64'hFFFF_FFFF_FFFF_FFFF and WE=1, then read with SA=31 -> A=0. A full sweep shows no register changed.
- WE=0 with SW=7 and W=64'h55 -> R[7] stays 0. Then WE=1 -> R[7]=64'h55 after the edge.
- Same-cycle read/write: R[3]=64'h10, then WE=1, SW=3, W=64'h20, SA=3 -> BYPASS=0 gives A=64'h10 before the edge; BYPASS=1 gives A=64'h20 before the edge. After the edge, A=64'h20 in both configurations.
- Reset priority: R[9]=64'hAA, then reset=1 with WE=1, SW=9, W=64'hBB at the same edge -> R[9]=0 afterwards. With reset=0 at the next edge, the same write gives R[9]=64'hBB.
